// File: rtl/mpu_fetch_pkg.sv
// Shared definitions for the MPU fetch/decode stage: opcodes, FSM states, length table.
// MPU_FETCH_BKPT_EN adds the HALT state used by the breakpoint feature.
package mpu_fetch_pkg;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_MASK  = 4'h2;
  localparam logic [3:0] OP_JMP   = 4'h3;

  localparam logic [2:0] LEN_MASK = 3'd5;
  localparam logic [2:0] LEN_JMP  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ERROR = 2'd2
`ifdef MPU_FETCH_BKPT_EN
    , ST_HALT = 2'd3
`endif
  } fetch_state_e;

  // LOAD length is opcode + register byte + 1/2/4 immediate bytes
  function automatic logic [2:0] load_len(input logic [1:0] size);
    case (size)
      2'd0:    load_len = 3'd3;
      2'd1:    load_len = 3'd4;
      2'd2:    load_len = 3'd6;
      default: load_len = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mpu_fetch_decode.sv
// Combinational decoder: 48-bit little-endian fetch window -> instruction fields,
// byte length and an illegal flag (unknown opcode, reserved bits or size set).
module mpu_fetch_decode
  import mpu_fetch_pkg::*;
(
  input  logic [47:0] mem_data_i,
  output logic [3:0]  op_o,
  output logic [1:0]  size_o,
  output logic [19:0] regs_o,
  output logic [31:0] imm_o,
  output logic [2:0]  len_o,
  output logic        illegal_o
);

  logic [1:0] size_s;
  logic [1:0] rsv_s;
  logic [2:0] unused_s;

  assign size_s   = mem_data_i[1:0];
  assign rsv_s    = mem_data_i[3:2];
  assign unused_s = mem_data_i[10:8];

  // Register operands live in the upper five bits of bytes 1..4
  always_comb begin
    op_o      = mem_data_i[7:4];
    size_o    = 2'd0;
    regs_o    = 20'd0;
    imm_o     = 32'd0;
    len_o     = 3'd0;
    illegal_o = 1'b1;
    case (mem_data_i[7:4])
      OP_LOAD: begin
        size_o    = size_s;
        len_o     = load_len(size_s);
        regs_o    = {15'd0, mem_data_i[15:11]};
        illegal_o = (size_s == 2'd3) || (rsv_s != 2'd0);
        case (size_s)
          2'd0:    imm_o = {24'd0, mem_data_i[23:16]};
          2'd1:    imm_o = {16'd0, mem_data_i[31:16]};
          2'd2:    imm_o = mem_data_i[47:16];
          default: imm_o = 32'd0;
        endcase
      end
      OP_MASK: begin
        len_o     = LEN_MASK;
        regs_o    = {mem_data_i[39:35], mem_data_i[31:27], mem_data_i[23:19], mem_data_i[15:11]};
        illegal_o = (mem_data_i[3:0] != 4'd0);
      end
      OP_JMP: begin
        len_o     = LEN_JMP;
        regs_o    = {15'd0, mem_data_i[15:11]};
        illegal_o = (mem_data_i[3:0] != 4'd0);
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mpu_fetch.sv
// MPU fetch/decode stage: PC, FSM, registered valid/ready output and redirect handling.
// Define MPU_FETCH_BKPT_EN to add the breakpoint (bkpt_en/bkpt_addr/resume, HALT state).
module mpu_fetch
  import mpu_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        run,
  output logic [15:0] mem_addr,
  input  logic [47:0] mem_data,
  output logic        i_valid,
  input  logic        i_ready,
  output logic [3:0]  i_op,
  output logic [1:0]  i_size,
  output logic [19:0] i_reg,
  output logic [31:0] i_imm,
  output logic [15:0] i_pc,
  input  logic        jmp_valid,
  input  logic [15:0] jmp_addr,
`ifdef MPU_FETCH_BKPT_EN
  input  logic        bkpt_en,
  input  logic [15:0] bkpt_addr,
  input  logic        resume,
`endif
  output logic        error,
  output logic        halted
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic         valid_q, valid_d;
  logic [3:0]   op_q, op_d;
  logic [1:0]   size_q, size_d;
  logic [19:0]  reg_q, reg_d;
  logic [31:0]  imm_q, imm_d;
  logic [15:0]  ipc_q, ipc_d;
  logic         error_q, error_d;
  logic         skip_q, skip_d;

  logic [3:0]   dec_op_s;
  logic [1:0]   dec_size_s;
  logic [19:0]  dec_regs_s;
  logic [31:0]  dec_imm_s;
  logic [2:0]   dec_len_s;
  logic         dec_illegal_s;
  logic         can_load_s;
  logic         crosses_s;

  mpu_fetch_decode u_decode (
    .mem_data_i (mem_data),
    .op_o       (dec_op_s),
    .size_o     (dec_size_s),
    .regs_o     (dec_regs_s),
    .imm_o      (dec_imm_s),
    .len_o      (dec_len_s),
    .illegal_o  (dec_illegal_s)
  );

  assign can_load_s = !valid_q || i_ready;
  // Ending exactly at 0xFFFF is fine (pc wraps to 0); reaching past it is not
  assign crosses_s  = ({1'b0, pc_q} + {14'd0, dec_len_s}) > 17'h10000;

  // Next-state: FSM, redirect, issue and output-register drain
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    size_d  = size_q;
    reg_d   = reg_q;
    imm_d   = imm_q;
    ipc_d   = ipc_q;
    error_d = error_q;
    skip_d  = skip_q;
    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (jmp_valid) begin
          pc_d    = jmp_addr;
          valid_d = 1'b0;
          skip_d  = 1'b0;
        end else begin
          pc_d = pc_q;
        end
        if (run) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (jmp_valid) begin
          pc_d    = jmp_addr;
          valid_d = 1'b0;
          skip_d  = 1'b0;
          state_d = run ? ST_RUN : ST_IDLE;
        end else if (!run) begin
          state_d = ST_IDLE;
        end else if (!can_load_s) begin
          state_d = ST_RUN;
`ifdef MPU_FETCH_BKPT_EN
        end else if (bkpt_en && (pc_q == bkpt_addr) && !skip_q) begin
          state_d = ST_HALT;
`endif
        end else if (dec_illegal_s || crosses_s) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          op_d    = dec_op_s;
          size_d  = dec_size_s;
          reg_d   = dec_regs_s;
          imm_d   = dec_imm_s;
          ipc_d   = pc_q;
          pc_d    = pc_q + {13'd0, dec_len_s};
          skip_d  = 1'b0;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
`ifdef MPU_FETCH_BKPT_EN
      ST_HALT: begin
        if (jmp_valid) begin
          pc_d    = jmp_addr;
          valid_d = 1'b0;
        end else begin
          pc_d = pc_q;
        end
        // skip lets the breakpointed instruction issue once after resume
        if (resume) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end else begin
          state_d = ST_HALT;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      op_q    <= 4'd0;
      size_q  <= 2'd0;
      reg_q   <= 20'd0;
      imm_q   <= 32'd0;
      ipc_q   <= 16'd0;
      error_q <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      size_q  <= size_d;
      reg_q   <= reg_d;
      imm_q   <= imm_d;
      ipc_q   <= ipc_d;
      error_q <= error_d;
      skip_q  <= skip_d;
    end
  end

  assign mem_addr = pc_q;
  assign i_valid  = valid_q;
  assign i_op     = op_q;
  assign i_size   = size_q;
  assign i_reg    = reg_q;
  assign i_imm    = imm_q;
  assign i_pc     = ipc_q;
  assign error    = error_q;
`ifdef MPU_FETCH_BKPT_EN
  assign halted   = (state_q == ST_HALT);
`else
  assign halted   = 1'b0;
`endif

endmodule

// File: tb/tb_mpu_fetch.sv
// Scoreboard bench for mpu_fetch: directed boundary cases plus a random instruction
// stream with random backpressure, run gaps and redirects. Covers MPU_FETCH_BKPT_EN if defined.
module tb_mpu_fetch;

  typedef struct packed {
    logic [15:0] pc;
    logic [3:0]  op;
    logic [1:0]  size;
    logic [19:0] regs;
    logic [31:0] imm;
  } exp_t;

  localparam int          PROG_N    = 400;
  localparam logic [15:0] PROG_BASE = 16'h2000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n, run, i_ready, jmp_valid;
  logic [15:0] jmp_addr, mem_addr, i_pc;
  logic [47:0] mem_data;
  logic        i_valid, error, halted;
  logic [3:0]  i_op;
  logic [1:0]  i_size;
  logic [19:0] i_reg;
  logic [31:0] i_imm;
`ifdef MPU_FETCH_BKPT_EN
  logic        bkpt_en, resume;
  logic [15:0] bkpt_addr;
`endif

  logic [7:0] mem [0:65535];
  exp_t       prog [0:PROG_N-1];
  exp_t       exp_q [$];
  int         vectors = 0;
  int         miscompares = 0;
  int         pops = 0;
  logic       done = 1'b0;

  mpu_fetch #(.RESET_PC(16'h0000)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .run       (run),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_op      (i_op),
    .i_size    (i_size),
    .i_reg     (i_reg),
    .i_imm     (i_imm),
    .i_pc      (i_pc),
    .jmp_valid (jmp_valid),
    .jmp_addr  (jmp_addr),
`ifdef MPU_FETCH_BKPT_EN
    .bkpt_en   (bkpt_en),
    .bkpt_addr (bkpt_addr),
    .resume    (resume),
`endif
    .error     (error),
    .halted    (halted)
  );

  always #5 sys_clk = ~sys_clk;

  // memory returns six bytes from mem_addr, wrapping at 64 KiB
  always_comb begin
    mem_data = 48'd0;
    for (int k = 0; k < 6; k++) mem_data[8*k +: 8] = mem[16'(mem_addr + 16'(k))];
  end

  function automatic exp_t mk(input logic [15:0] pc, input logic [3:0] op, input logic [1:0] size,
                              input logic [19:0] regs, input logic [31:0] imm);
    exp_t e;
    e.pc = pc; e.op = op; e.size = size; e.regs = regs; e.imm = imm;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    do begin @(negedge sys_clk); n++; end while (!i_valid && n < 20);
    check(name, 32'(i_valid), 32'd1);
  endtask

  task automatic wait_error(input string name);
    int n = 0;
    do begin @(negedge sys_clk); n++; end while (!error && n < 20);
    check(name, 32'(error), 32'd1);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check("rst_error", 32'(error), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_valid", 32'(i_valid), 32'd0);
    tick();
    sys_rst_n = 1'b1;
  endtask

  task automatic jump_idle(input logic [15:0] target);
    tick();
    jmp_valid = 1'b1; jmp_addr = target;
    tick();
    jmp_valid = 1'b0;
  endtask

  // random program of LOAD/MASK/JMP; fields chosen first, then encoded into bytes
  task automatic gen_program();
    logic [15:0] a;
    logic [1:0]  sz;
    logic [31:0] imm;
    logic [4:0]  r [4];
    int          nb;
    exp_t        e;
    a = PROG_BASE;
    for (int i = 0; i < PROG_N; i++) begin
      for (int k = 0; k < 4; k++) r[k] = 5'($urandom_range(0, 31));
      e = mk(a, 4'h3, 2'd0, {15'd0, r[0]}, 32'd0);
      mem[a + 16'd1] = {r[0], 3'($urandom_range(0, 7))};
      case ($urandom_range(0, 2))
        0: begin
          sz  = 2'($urandom_range(0, 2));
          nb  = 1 << sz;
          imm = $urandom;
          if (nb < 4) imm = imm & ((32'd1 << (8 * nb)) - 32'd1);
          e.op = 4'h1; e.size = sz; e.imm = imm;
          mem[a] = {4'h1, 2'b00, sz};
          for (int b = 0; b < nb; b++) mem[a + 16'(2 + b)] = imm[8*b +: 8];
          a = a + 16'(2 + nb);
        end
        1: begin
          e.op = 4'h2; e.regs = {r[3], r[2], r[1], r[0]};
          mem[a] = 8'h20;
          for (int k = 1; k < 4; k++) mem[a + 16'(k + 1)] = {r[k], 3'($urandom_range(0, 7))};
          a = a + 16'd5;
        end
        default: begin
          mem[a] = 8'h30;
          a = a + 16'd2;
        end
      endcase
      prog[i] = e;
    end
  endtask

  initial begin
    sys_rst_n = 1'b0; run = 1'b0; i_ready = 1'b0; jmp_valid = 1'b0; jmp_addr = 16'h0;
`ifdef MPU_FETCH_BKPT_EN
    bkpt_en = 1'b0; bkpt_addr = 16'h0; resume = 1'b0;
`endif
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[0] = 8'h10; mem[1] = 8'h00; mem[2] = 8'hFF;
    mem[3] = 8'h11; mem[4] = 8'h18; mem[5] = 8'hFF; mem[6] = 8'h00;
    mem[7] = 8'h20; mem[8] = 8'h00; mem[9] = 8'h08; mem[10] = 8'h10; mem[11] = 8'h18;
    mem[12] = 8'h30; mem[13] = 8'h20;
    mem[16] = 8'h13;
    gen_program();

    fork
      begin : monitor
        exp_t got, want;
        while (!done) begin
          @(negedge sys_clk);
          if (sys_rst_n && i_valid && i_ready) begin
            got = {i_pc, i_op, i_size, i_reg, i_imm};
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++;
              $display("FAIL issue_unexpected: got pc=%h op=%h, required no instruction", i_pc, i_op);
            end else begin
              want = exp_q.pop_front();
              pops++;
              if (got !== want) begin
                miscompares++;
                $display("FAIL issue: got pc=%h op=%h size=%h reg=%h imm=%h, required pc=%h op=%h size=%h reg=%h imm=%h",
                         i_pc, i_op, i_size, i_reg, i_imm, want.pc, want.op, want.size, want.regs, want.imm);
              end
            end
          end
        end
      end

      begin : stim
        repeat (3) @(negedge sys_clk);
        check("rst_valid", 32'(i_valid), 32'd0);
        check("rst_pc_out", 32'(i_pc), 32'h0);
        check("rst_op", 32'(i_op), 32'h0);
        check("rst_imm", i_imm, 32'h0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        tick();
        sys_rst_n = 1'b1;

        // back-to-back LOADs, then MASK held under backpressure
        exp_q.push_back(mk(16'h0000, 4'h1, 2'd0, 20'd0, 32'hFF));
        exp_q.push_back(mk(16'h0003, 4'h1, 2'd1, 20'd3, 32'hFF));
        tick();
        run = 1'b1; i_ready = 1'b1;
        wait_valid("first_valid");
        check("first_pc", 32'(i_pc), 32'h0);
        @(negedge sys_clk);
        check("second_valid", 32'(i_valid), 32'd1);
        check("second_pc", 32'(i_pc), 32'h3);
        tick();
        i_ready = 1'b0;
        exp_q.push_back(mk(16'h0007, 4'h2, 2'd0, 20'h18820, 32'd0));
        repeat (3) begin
          @(negedge sys_clk);
          check("stall_valid", 32'(i_valid), 32'd1);
          check("stall_pc", 32'(i_pc), 32'h7);
          check("stall_reg", 32'(i_reg), 32'h18820);
          check("stall_mem_addr", 32'(mem_addr), 32'hC);
        end
        tick();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0; jmp_valid = 1'b1; jmp_addr = 16'h0000;
        @(negedge sys_clk);
        check("jmp_presented_pc", 32'(i_pc), 32'hC);
        tick();
        jmp_valid = 1'b0; i_ready = 1'b1;
        exp_q.push_back(mk(16'h0000, 4'h1, 2'd0, 20'd0, 32'hFF));
        @(negedge sys_clk);
        check("flush_valid", 32'(i_valid), 32'd0);
        tick();
        run = 1'b0;
        @(negedge sys_clk);
        check("refetch_pc", 32'(i_pc), 32'h0);
        tick();
        @(negedge sys_clk);
        check("drain_valid", 32'(i_valid), 32'd0);

        // illegal size at 0x0010: sticky error, jump ignored
        jump_idle(16'h0010);
        run = 1'b1;
        wait_error("illegal_error");
        check("illegal_pc_hold", 32'(mem_addr), 32'h10);
        check("illegal_no_valid", 32'(i_valid), 32'd0);
        tick();
        run = 1'b0;
        jump_idle(16'h0040);
        repeat (2) tick();
        @(negedge sys_clk);
        check("error_sticky", 32'(error), 32'd1);
        check("error_ignores_jmp", 32'(mem_addr), 32'h10);
        tick();
        do_reset();

        // instruction crossing 0xFFFF faults; ending at 0xFFFF wraps
        mem[16'hFFFC] = 8'h12;
        jump_idle(16'hFFFC);
        run = 1'b1;
        wait_error("cross_error");
        check("cross_pc_hold", 32'(mem_addr), 32'hFFFC);
        tick();
        run = 1'b0;
        do_reset();
        mem[16'hFFFD] = 8'h10; mem[16'hFFFE] = 8'h2D; mem[16'hFFFF] = 8'hA5;
        exp_q.push_back(mk(16'hFFFD, 4'h1, 2'd0, 20'd5, 32'hA5));
        i_ready = 1'b0;
        jump_idle(16'hFFFD);
        run = 1'b1;
        wait_valid("wrap_valid");
        check("wrap_pc", 32'(i_pc), 32'hFFFD);
        check("wrap_mem_addr", 32'(mem_addr), 32'h0);
        check("wrap_no_error", 32'(error), 32'd0);
        tick();
        run = 1'b0; i_ready = 1'b1;
        tick();
        @(negedge sys_clk);
        check("wrap_drained", 32'(i_valid), 32'd0);

`ifdef MPU_FETCH_BKPT_EN
        jump_idle(16'h0000);
        bkpt_en = 1'b1; bkpt_addr = 16'h0003;
        exp_q.push_back(mk(16'h0000, 4'h1, 2'd0, 20'd0, 32'hFF));
        run = 1'b1; i_ready = 1'b1;
        begin
          int n = 0;
          do begin @(negedge sys_clk); n++; end while (!halted && n < 20);
        end
        check("bkpt_halted", 32'(halted), 32'd1);
        check("bkpt_pc", 32'(mem_addr), 32'h3);
        tick();
        i_ready = 1'b0; resume = 1'b1;
        exp_q.push_back(mk(16'h0003, 4'h1, 2'd1, 20'd3, 32'hFF));
        tick();
        resume = 1'b0;
        wait_valid("resume_valid");
        check("resume_pc", 32'(i_pc), 32'h3);
        check("resume_halted", 32'(halted), 32'd0);
        tick();
        run = 1'b0; i_ready = 1'b1; bkpt_en = 1'b0;
        repeat (2) tick();
`endif

        // random stream with backpressure, run gaps and redirects
        for (int cyc = 0; cyc < 3000; cyc++) begin
          tick();
          i_ready = ($urandom_range(0, 3) != 0);
          run     = ($urandom_range(0, 15) != 0);
          if (exp_q.size() < 8 || $urandom_range(0, 63) == 0) begin
            int k;
            k = $urandom_range(0, PROG_N - 20);
            jmp_valid = 1'b1;
            jmp_addr  = prog[k].pc;
            @(negedge sys_clk);
            #1;
            exp_q.delete();
            for (int j = k; j < PROG_N; j++) exp_q.push_back(prog[j]);
          end else begin
            jmp_valid = 1'b0;
          end
        end
        tick();
        run = 1'b0; jmp_valid = 1'b0; i_ready = 1'b1;
        repeat (4) tick();
        @(negedge sys_clk);
        check("random_no_error", 32'(error), 32'd0);
        check("random_progress", 32'(pops > 500), 32'd1);
        done = 1'b1;
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
